drvr_fifo_bank: RTL

Bank of `drvrs` independent first-word-fall-through FIFOs that sit directly upstream of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). Each FIFO buffers packets written by one device-side agent and presents them to the bus through the `pndng` / `pop` / `D_pop` handshake. The arbiter pops one packet at a time from whichever FIFO it grants. Per-FIFO occupancy and sticky overflow/underflow flags are exported for the checker and scoreboard.

---
 rtl/drvr_fifo_bank_if.sv | 29 ++
 rtl/drvr_fifo_bank.sv | 100 ++++++++++
 2 files changed

// File: rtl/drvr_fifo_bank_if.sv
// Device-side write port and arbiter-side pop port of the FIFO bank, with per-FIFO status.
// master = agents/arbiter driving the bank, slave = the bank itself.
interface drvr_fifo_bank_if #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned drvrs   = 8,
    parameter int unsigned depth   = 16
);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic [drvrs-1:0]         wr_en;
    logic [drvrs*pckg_sz-1:0] wr_data;
    logic [drvrs-1:0]         full;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs*cnt_w-1:0]   count;
    logic [drvrs-1:0]         ovf;
    logic [drvrs-1:0]         udf;

    modport master (
        output wr_en, wr_data, pop,
        input  full, pndng, D_pop, count, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, pop,
        output full, pndng, D_pop, count, ovf, udf
    );
endinterface

// File: rtl/drvr_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs feeding the bus arbiter, one per device port.
// Each FIFO exports occupancy plus sticky overflow/underflow flags.
module drvr_fifo_bank #(
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned drvrs   = 8,
    parameter int unsigned depth   = 16
) (
    input logic              clk,
    input logic              reset,
    drvr_fifo_bank_if.slave  bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic [drvrs-1:0]         full_v;
    logic [drvrs-1:0]         pndng_v;
    logic [drvrs-1:0]         ovf_v;
    logic [drvrs-1:0]         udf_v;
    logic [drvrs*pckg_sz-1:0] d_pop_v;
    logic [drvrs*cnt_w-1:0]   count_v;

    for (genvar d = 0; d < drvrs; d++) begin : g_fifo
        logic [pckg_sz-1:0] mem_q [depth];
        logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
        logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
        logic [cnt_w-1:0]   count_q, count_d;
        logic               ovf_q, ovf_d;
        logic               udf_q, udf_d;
        logic               is_full, is_pndng;
        logic               wr_acc, pop_acc;

        assign is_full  = (count_q == cnt_w'(depth));
        assign is_pndng = (count_q != '0);
        // A pop frees the head slot in the same edge, so a full FIFO can still take a write.
        assign wr_acc   = bus.wr_en[d] && (!is_full || bus.pop[d]);
        assign pop_acc  = bus.pop[d] && is_pndng;

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            ovf_d    = ovf_q;
            udf_d    = udf_q;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ptr_w'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + ptr_w'(1);
            end
            if (wr_acc && !pop_acc) begin
                count_d = count_q + cnt_w'(1);
            end else if (pop_acc && !wr_acc) begin
                count_d = count_q - cnt_w'(1);
            end
            if (bus.wr_en[d] && is_full && !bus.pop[d]) begin
                ovf_d = 1'b1;
            end
            if (bus.pop[d] && !is_pndng) begin
                udf_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
                udf_q    <= udf_d;
            end
        end

        // Storage has no reset; stale entries are unreachable once the pointers clear.
        always_ff @(posedge clk) begin
            if (!reset && wr_acc) begin
                mem_q[wr_ptr_q] <= bus.wr_data[d*pckg_sz +: pckg_sz];
            end
        end

        assign full_v[d]                       = is_full;
        assign pndng_v[d]                      = is_pndng;
        assign ovf_v[d]                        = ovf_q;
        assign udf_v[d]                        = udf_q;
        assign count_v[d*cnt_w +: cnt_w]       = count_q;
        assign d_pop_v[d*pckg_sz +: pckg_sz]   = is_pndng ? mem_q[rd_ptr_q] : '0;
    end

    assign bus.full  = full_v;
    assign bus.pndng = pndng_v;
    assign bus.ovf   = ovf_v;
    assign bus.udf   = udf_v;
    assign bus.count = count_v;
    assign bus.D_pop = d_pop_v;
endmodule
